// File: rtl/mul_operand_packer_bf16.sv
// Operand packer feeding the 4-lane bf16 multiplier tree: collects one node's operands
// into a 128-bit word, issues it under credit control and tracks batches in flight.
module mul_operand_packer_bf16 #(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter logic [15:0] ONE_BF16     = 16'h3F80
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  op_in,
    input  logic [1:0]   op_mode,
    input  logic         op_valid,
    output logic         op_ready,
    output logic [127:0] mul_ins,
    output logic         mul_stb,
    output logic [1:0]   mode,
    input  logic [3:0]   tree_stbs,
    output logic [3:0]   inflight,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_INFLIGHT);

    state_t       state_r;
    state_t       state_s;
    logic [2:0]   ptr_r;
    logic [2:0]   ptr_s;
    logic [127:0] ins_s;
    logic [1:0]   mode_s;
    logic [3:0]   inflight_s;
    logic         stb_s;
    logic         err_s;
    logic         retire_s;
    logic         live_r;

    assign retire_s = |tree_stbs;
    assign busy     = (state_r != IDLE) || (inflight != 4'd0);

    // Group assembly: slot writes, pointer sequencing and handshake
    always_comb begin
        state_s  = state_r;
        ptr_s    = ptr_r;
        ins_s    = mul_ins;
        mode_s   = mode;
        op_ready = 1'b0;
        case (state_r)
            IDLE: begin
                // A new mode must wait for the tree to drain so mode stays stable for in-flight products
                op_ready = live_r && ((inflight == 4'd0) || (op_mode == mode));
                if (op_valid && op_ready) begin
                    mode_s       = op_mode;
                    ins_s[15:0]  = op_in;
                    ptr_s        = 3'd1;
                    state_s      = FILL;
                end else begin
                    state_s = IDLE;
                end
            end
            FILL: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    ins_s[{ptr_r, 4'd0} +: 16] = op_in;
                    if ((mode == 2'd1) && (ptr_r == 3'd2)) begin
                        ins_s[63:48] = ONE_BF16;
                        ptr_s        = 3'd4;
                    end else if ((mode == 2'd1) && (ptr_r == 3'd6)) begin
                        ins_s[127:112] = ONE_BF16;
                        state_s        = ISSUE;
                    end else if (ptr_r == 3'd7) begin
                        state_s = ISSUE;
                    end else begin
                        ptr_s = ptr_r + 3'd1;
                    end
                end else begin
                    state_s = FILL;
                end
            end
            ISSUE: begin
                if (mul_stb) begin
                    ptr_s   = 3'd0;
                    state_s = IDLE;
                end else begin
                    state_s = ISSUE;
                end
            end
            default: begin
                state_s = IDLE;
                ptr_s   = 3'd0;
            end
        endcase
    end

    // Credit accounting, issue strobe and sticky underflow error
    always_comb begin
        inflight_s = inflight;
        case ({mul_stb, retire_s})
            2'b10:   inflight_s = inflight + 4'd1;
            2'b01: begin
                if (inflight != 4'd0) begin
                    inflight_s = inflight - 4'd1;
                end else begin
                    inflight_s = 4'd0;
                end
            end
            default: inflight_s = inflight;
        endcase
        // The strobe is registered one cycle ahead so it coincides with the ISSUE state
        stb_s = (state_s == ISSUE) && (inflight_s < MAX_CNT);
        err_s = err || (retire_s && (inflight == 4'd0));
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            ptr_r    <= 3'd0;
            mul_ins  <= 128'd0;
            mul_stb  <= 1'b0;
            mode     <= 2'd0;
            inflight <= 4'd0;
            err      <= 1'b0;
            live_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            ptr_r    <= ptr_s;
            mul_ins  <= ins_s;
            mul_stb  <= stb_s;
            mode     <= mode_s;
            inflight <= inflight_s;
            err      <= err_s;
            live_r   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mul_operand_packer_bf16.sv
// Self-checking bench for mul_operand_packer_bf16: directed scenarios plus randomized
// groups compared against a slot-level packing model.
module tb_mul_operand_packer_bf16;

    localparam logic [15:0] ONE = 16'h3F80;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [15:0]  op_in = 16'd0;
    logic [1:0]   op_mode = 2'd0;
    logic         op_valid = 1'b0;
    logic         op_ready;
    logic [127:0] mul_ins;
    logic         mul_stb;
    logic [1:0]   mode;
    logic [3:0]   tree_stbs = 4'd0;
    logic [3:0]   inflight;
    logic         busy;
    logic         err;

    int total = 0;
    int bad = 0;
    int exp_inflight = 0;
    int stb_count = 0;
    logic [15:0] g_ops [8];

    mul_operand_packer_bf16 #(.MAX_INFLIGHT(4), .ONE_BF16(16'h3F80)) dut (
        .clk(clk), .rst(rst), .op_in(op_in), .op_mode(op_mode), .op_valid(op_valid),
        .op_ready(op_ready), .mul_ins(mul_ins), .mul_stb(mul_stb), .mode(mode),
        .tree_stbs(tree_stbs), .inflight(inflight), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mul_stb === 1'b1) stb_count++;

    // Model: operands land in slots in order; three-input nodes pad slots 3 and 7 with 1.0
    function automatic logic [127:0] pack(input logic [1:0] m);
        logic [15:0] slots [8];
        logic [127:0] w;
        if (m == 2'd1) begin
            slots[0] = g_ops[0]; slots[1] = g_ops[1]; slots[2] = g_ops[2]; slots[3] = ONE;
            slots[4] = g_ops[3]; slots[5] = g_ops[4]; slots[6] = g_ops[5]; slots[7] = ONE;
        end else begin
            for (int i = 0; i < 8; i++) slots[i] = g_ops[i];
        end
        w = 128'd0;
        for (int i = 0; i < 8; i++) w[16*i +: 16] = slots[i];
        return w;
    endfunction

    task automatic send_beat(input logic [15:0] d, input logic [1:0] m);
        bit ok;
        ok = 1'b0;
        op_in = d; op_mode = m; op_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (op_ready === 1'b1) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        op_valid = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL beat_accept got=no_accept want=accept data=%h", d); end
    endtask

    task automatic send_group(input logic [1:0] m, input int gap_max);
        int n;
        n = (m == 2'd1) ? 6 : 8;
        for (int k = 0; k < n; k++) begin
            if (gap_max > 0) begin
                op_valid = 1'b0;
                repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            end
            if (k == 0 || gap_max == 0) send_beat(g_ops[k], m);
            else send_beat(g_ops[k], 2'($urandom_range(0, 3)));
        end
    endtask

    task automatic check_issue(input logic [1:0] m, input logic [127:0] want, input string tag);
        int waited;
        waited = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mul_stb === 1'b1) begin waited = i; break; end
        end
        total++;
        if (waited != 0) begin bad++; $display("FAIL %s_stb_latency got=%0d want=0", tag, waited); end
        if (waited >= 0) begin
            total++;
            if (mul_ins !== want) begin bad++; $display("FAIL %s_mul_ins got=%h want=%h", tag, mul_ins, want); end
            total++;
            if (mode !== m) begin bad++; $display("FAIL %s_mode got=%0d want=%0d", tag, mode, m); end
        end
        @(posedge clk); #1;
        exp_inflight++;
        total++;
        if (mul_stb !== 1'b0) begin bad++; $display("FAIL %s_stb_width got=%b want=0", tag, mul_stb); end
        total++;
        if (inflight !== 4'(exp_inflight)) begin bad++; $display("FAIL %s_inflight got=%0d want=%0d", tag, inflight, exp_inflight); end
    endtask

    task automatic pulse_retire(input logic [3:0] pattern);
        tree_stbs = pattern;
        @(posedge clk); #1;
        tree_stbs = 4'd0;
        if (exp_inflight > 0) exp_inflight--;
    endtask

    task automatic drain();
        while (exp_inflight > 0) pulse_retire(4'b0001);
        total++;
        if (inflight !== 4'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL drain got=inflight %0d busy %b want=inflight 0 busy 0", inflight, busy);
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({op_ready, mul_stb, mode, inflight, busy, err} !== 10'd0 || mul_ins !== 128'd0) begin
            bad++; $display("FAIL reset_outputs got=%b/%h want=0", {op_ready, mul_stb, mode, inflight, busy, err}, mul_ins);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        send_beat(16'hA001, 2'd0);
        send_beat(16'hA002, 2'd0);
        send_beat(16'hA003, 2'd0);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL midfill_busy got=%b want=1", busy); end
        rst = 1'b0;
        #2;
        total++;
        if ({op_ready, mul_stb, mode, inflight, busy, err} !== 10'd0 || mul_ins !== 128'd0) begin
            bad++; $display("FAIL midfill_reset got=%b/%h want=0", {op_ready, mul_stb, mode, inflight, busy, err}, mul_ins);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_inflight = 0;
    endtask

    task automatic test_mode0();
        for (int i = 0; i < 8; i++) g_ops[i] = 16'(i + 1);
        send_group(2'd0, 0);
        check_issue(2'd0, 128'h0008_0007_0006_0005_0004_0003_0002_0001, "mode0");
    endtask

    task automatic test_mode1();
        drain();
        for (int i = 0; i < 8; i++) g_ops[i] = 16'(i + 1);
        send_group(2'd1, 0);
        check_issue(2'd1, 128'h3F80_0006_0005_0004_3F80_0003_0002_0001, "mode1");
    endtask

    task automatic test_credit();
        logic [127:0] want5;
        drain();
        stb_count = 0;
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < 8; i++) g_ops[i] = 16'($urandom);
            send_group(2'd2, 0);
        end
        want5 = pack(2'd2);
        repeat (3) begin @(posedge clk); #1; end
        op_valid = 1'b1; op_mode = 2'd2;
        @(negedge clk);
        total++;
        if (stb_count != 4) begin bad++; $display("FAIL credit_stb_count got=%0d want=4", stb_count); end
        total++;
        if (inflight !== 4'd4) begin bad++; $display("FAIL credit_inflight got=%0d want=4", inflight); end
        total++;
        if (op_ready !== 1'b0 || mul_stb !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL credit_stall got=ready %b stb %b busy %b want=0 0 1", op_ready, mul_stb, busy);
        end
        @(posedge clk); #1;
        op_valid = 1'b0;
        tree_stbs = 4'b0011;
        @(posedge clk); #1;
        tree_stbs = 4'd0;
        @(negedge clk);
        total++;
        if (mul_stb !== 1'b1 || inflight !== 4'd3) begin
            bad++; $display("FAIL credit_release got=stb %b inflight %0d want=1 3", mul_stb, inflight);
        end
        total++;
        if (mul_ins !== want5) begin bad++; $display("FAIL credit_mul_ins got=%h want=%h", mul_ins, want5); end
        @(posedge clk); #1;
        total++;
        if (inflight !== 4'd4 || mul_stb !== 1'b0 || stb_count != 5) begin
            bad++; $display("FAIL credit_after got=inflight %0d stb %b count %0d want=4 0 5", inflight, mul_stb, stb_count);
        end
        exp_inflight = 4;
        drain();
    endtask

    task automatic test_mode_change();
        for (int i = 0; i < 8; i++) g_ops[i] = 16'($urandom);
        send_group(2'd0, 0);
        check_issue(2'd0, pack(2'd0), "mc_first");
        op_valid = 1'b1; op_mode = 2'd3; op_in = 16'h1234;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (op_ready !== 1'b0 || mode !== 2'd0) begin
                bad++; $display("FAIL mc_stall got=ready %b mode %0d want=0 0", op_ready, mode);
            end
        end
        @(posedge clk); #1;
        tree_stbs = 4'b1000;
        @(negedge clk);
        total++;
        if (op_ready !== 1'b0) begin bad++; $display("FAIL mc_retire_cycle got=%b want=0", op_ready); end
        @(posedge clk); #1;
        tree_stbs = 4'd0;
        exp_inflight = 0;
        @(negedge clk);
        total++;
        if (inflight !== 4'd0 || op_ready !== 1'b1 || mode !== 2'd0) begin
            bad++; $display("FAIL mc_drained got=inflight %0d ready %b mode %0d want=0 1 0", inflight, op_ready, mode);
        end
        @(posedge clk); #1;
        op_valid = 1'b0;
        total++;
        if (mode !== 2'd3) begin bad++; $display("FAIL mc_new_mode got=%0d want=3", mode); end
        g_ops[0] = 16'h1234;
        for (int i = 1; i < 8; i++) begin
            g_ops[i] = 16'($urandom);
            send_beat(g_ops[i], 2'd0);
        end
        check_issue(2'd3, pack(2'd3), "mc_six");
    endtask

    task automatic test_simul_and_err();
        for (int i = 0; i < 8; i++) g_ops[i] = 16'($urandom);
        send_group(2'd3, 0);
        tree_stbs = 4'b0100;
        @(negedge clk);
        total++;
        if (mul_stb !== 1'b1) begin bad++; $display("FAIL simul_stb got=%b want=1", mul_stb); end
        @(posedge clk); #1;
        tree_stbs = 4'd0;
        total++;
        if (inflight !== 4'd1) begin bad++; $display("FAIL simul_inflight got=%0d want=1", inflight); end
        drain();
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", err); end
        tree_stbs = 4'b1111;
        @(posedge clk); #1;
        tree_stbs = 4'd0;
        total++;
        if (err !== 1'b1 || inflight !== 4'd0) begin
            bad++; $display("FAIL err_set got=err %b inflight %0d want=1 0", err, inflight);
        end
        repeat (5) begin @(posedge clk); #1; end
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", err); end
    endtask

    task automatic test_random();
        logic [1:0] m;
        logic [1:0] cur_mode;
        cur_mode = 2'd3;
        for (int g = 0; g < 24; g++) begin
            m = 2'($urandom_range(0, 3));
            if (exp_inflight > 0 && (m != cur_mode || exp_inflight >= 4)) drain();
            else if (exp_inflight > 0 && $urandom_range(0, 1) == 1) pulse_retire(4'($urandom_range(1, 15)));
            for (int i = 0; i < 8; i++) g_ops[i] = 16'($urandom);
            send_group(m, 2);
            check_issue(m, pack(m), "random");
            cur_mode = m;
        end
        drain();
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL random_err_hold got=%b want=1", err); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_credit();
        test_mode_change();
        test_simul_and_err();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
